rot_cordic_iter: RTL and testbench
==================================

Name: rot_cordic_iter

Overview:
- Iterative rotation-mode CORDIC engine in the QAM-16 receiver carrier/phase-correction path.
- Accepts one (x, y, phase) sample and rotates the vector by phase, one micro-rotation per clock.
- Delivers raw, gain-uncompensated x/y results over a valid/ready handshake.
- Output feeds the downstream 0.60725 gain-compensation constant multiplier directly.

Parameters:
- WIDTH, 16, signed data width of x/y inputs and outputs.
- ITER, 14, number of micro-rotations, legal range 1..16.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input sample valid.
- in_ready  output  1  engine can accept a sample.
- x_in  input  WIDTH  signed I component.
- y_in  input  WIDTH  signed Q component.
- phase_in  input  16  signed binary angle; -32768..32767 maps to -pi..+pi(1-2^-15).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- x_out  output  WIDTH  signed rotated I, times CORDIC gain (~1.6468), saturated.
- y_out  output  WIDTH  signed rotated Q, times CORDIC gain, saturated.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, in_ready=1, out_valid=0, x_out=0, y_out=0, iteration counter=0.
  - Reset mid-operation abandons the sample; no output is produced for it.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, load the pre-rotated vector, counter=0, go to ROTATE.
  - ROTATE: in_ready=0. Perform one micro-rotation per cycle for counter=0..ITER-1. After iteration ITER-1, register the saturated results and go to DONE.
  - DONE: out_valid=1, outputs held stable. On out_ready=1 go to IDLE. out_valid deasserts the next cycle.
- Throughput and latency:
  - No overlap: a new sample is accepted only in IDLE.
  - Minimum accept-to-accept interval is ITER+2 cycles.
  - Latency: acceptance at edge N puts out_valid high after edge N+ITER.
- Internal widths:
  - x, y registers are WIDTH+2 bits signed.
  - z register is 17 bits signed.
- Pre-rotation at load:
  - phase > 16384: x0=-y_in, y0=x_in, z0=phase-16384.
  - phase < -16384: x0=y_in, y0=-x_in, z0=phase+16384.
  - Otherwise: x0=x_in, y0=y_in, z0=phase.
  - The -32768 boundary takes the second branch.
- Micro-rotation i:
  - d=+1 if z>=0, else -1.
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*A[i].
  - Shifts are arithmetic.
- Arctan table A[0..15]: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- Output conversion:
  - Truncate to WIDTH bits with saturation to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - No rounding; no gain compensation in this block.
- Handshake boundaries:
  - in_valid during ROTATE/DONE is ignored; the upstream holds it.
  - out_ready while out_valid=0 has no effect.
  - Back-to-back: out_ready=1 in DONE returns to IDLE. A waiting in_valid is accepted on the following edge; no combinational ready path from out_ready to in_ready.
  - x_in=y_in=0 produces 0,0 for any phase.

Test Plan:
- Phase zero: x_in=8192, y_in=0, phase=0 -> after ITER cycles x_out=13491±4, y_out=0±4.
- Pre-rotation branch 1: x_in=8192, y_in=0, phase=16384 -> x_out=0±4, y_out=13491±4.
- -pi boundary: x_in=8192, y_in=0, phase=-32768 -> x_out=-13491±4, y_out=0±4.
- Saturation: x_in=16383, y_in=16383, phase=8192 -> x_out=0±4, y_out=32767.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and outputs stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE next cycle, pending sample accepted the cycle after.
- Reset mid-ROTATE: assert rst at iteration 5 -> out_valid=0, in_ready=1 immediately. Next sample (8192, 0, 0) completes normally with x_out=13491±4.

Source files
------------

// File: rtl/rot_cordic_iter_if.sv
// Sample-in / result-out handshake bundle for the rotation CORDIC engine.
// The master side is the upstream/downstream pair; the slave side is the engine.
interface rot_cordic_iter_if #(
   parameter int WIDTH = 16
) ();
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] x_in;
   logic signed [WIDTH-1:0] y_in;
   logic signed [15:0]      phase_in;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] x_out;
   logic signed [WIDTH-1:0] y_out;

   modport master (
      output in_valid, x_in, y_in, phase_in, out_ready,
      input  in_ready, out_valid, x_out, y_out
   );

   modport slave (
      input  in_valid, x_in, y_in, phase_in, out_ready,
      output in_ready, out_valid, x_out, y_out
   );
endinterface

// File: rtl/rot_cordic_iter.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, raw (gain ~1.6468)
// saturated x/y results held in DONE until the downstream takes them.
module rot_cordic_iter #(
   parameter int WIDTH = 16,
   parameter int ITER  = 14
) (
   input  logic             clk,
   input  logic             rst,
   rot_cordic_iter_if.slave bus
);
   localparam int XW = WIDTH + 2;

   typedef enum logic [1:0] {StIdle, StRotate, StDone} state_t;

   state_t                  r_state, w_state_nxt;
   logic signed [XW-1:0]    r_x, r_y, w_x_nxt, w_y_nxt;
   logic signed [16:0]      r_z, w_z_nxt;
   logic        [4:0]       r_cnt, w_cnt_nxt;
   logic signed [WIDTH-1:0] r_x_out, r_y_out, w_x_out_nxt, w_y_out_nxt;

   logic signed [XW-1:0]    w_xi, w_yi, w_xs, w_ys, w_x_rot, w_y_rot;
   logic signed [16:0]      w_ph, w_atan, w_z_rot;
   logic                    w_dir_pos;

   function automatic logic signed [16:0] atan_lut(input logic [4:0] idx);
      case (idx)
         5'd0:    atan_lut = 17'sd8192;
         5'd1:    atan_lut = 17'sd4836;
         5'd2:    atan_lut = 17'sd2555;
         5'd3:    atan_lut = 17'sd1297;
         5'd4:    atan_lut = 17'sd651;
         5'd5:    atan_lut = 17'sd326;
         5'd6:    atan_lut = 17'sd163;
         5'd7:    atan_lut = 17'sd81;
         5'd8:    atan_lut = 17'sd41;
         5'd9:    atan_lut = 17'sd20;
         5'd10:   atan_lut = 17'sd10;
         5'd11:   atan_lut = 17'sd5;
         5'd12:   atan_lut = 17'sd3;
         5'd13:   atan_lut = 17'sd1;
         5'd14:   atan_lut = 17'sd1;
         default: atan_lut = 17'sd0;
      endcase
   endfunction

   // In range only when the two guard bits match the WIDTH-bit sign bit.
   function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
      if (v[XW-1:WIDTH-1] == {3{v[XW-1]}}) begin
         sat = v[WIDTH-1:0];
      end else if (v[XW-1]) begin
         sat = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
         sat = {1'b0, {(WIDTH-1){1'b1}}};
      end
   endfunction

   assign w_xi = {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
   assign w_yi = {{2{bus.y_in[WIDTH-1]}}, bus.y_in};
   assign w_ph = {bus.phase_in[15], bus.phase_in};

   assign w_dir_pos = ~r_z[16];
   assign w_xs      = r_x >>> r_cnt;
   assign w_ys      = r_y >>> r_cnt;
   assign w_atan    = atan_lut(r_cnt);
   assign w_x_rot   = w_dir_pos ? (r_x - w_ys) : (r_x + w_ys);
   assign w_y_rot   = w_dir_pos ? (r_y + w_xs) : (r_y - w_xs);
   assign w_z_rot   = w_dir_pos ? (r_z - w_atan) : (r_z + w_atan);

   always_comb begin
      w_state_nxt   = r_state;
      w_x_nxt       = r_x;
      w_y_nxt       = r_y;
      w_z_nxt       = r_z;
      w_cnt_nxt     = r_cnt;
      w_x_out_nxt   = r_x_out;
      w_y_out_nxt   = r_y_out;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (r_state)
         StIdle: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               // Fold the angle into +/-90 deg so the micro-rotations converge.
               if (bus.phase_in > 16'sd16384) begin
                  w_x_nxt = -w_yi;
                  w_y_nxt = w_xi;
                  w_z_nxt = w_ph - 17'sd16384;
               end else if (bus.phase_in < -16'sd16384) begin
                  w_x_nxt = w_yi;
                  w_y_nxt = -w_xi;
                  w_z_nxt = w_ph + 17'sd16384;
               end else begin
                  w_x_nxt = w_xi;
                  w_y_nxt = w_yi;
                  w_z_nxt = w_ph;
               end
               w_cnt_nxt   = 5'd0;
               w_state_nxt = StRotate;
            end
         end
         StRotate: begin
            w_x_nxt   = w_x_rot;
            w_y_nxt   = w_y_rot;
            w_z_nxt   = w_z_rot;
            w_cnt_nxt = r_cnt + 5'd1;
            if (r_cnt == 5'(ITER - 1)) begin
               w_x_out_nxt = sat(w_x_rot);
               w_y_out_nxt = sat(w_y_rot);
               w_state_nxt = StDone;
            end
         end
         StDone: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_cnt   <= '0;
         r_x_out <= '0;
         r_y_out <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_x     <= w_x_nxt;
         r_y     <= w_y_nxt;
         r_z     <= w_z_nxt;
         r_cnt   <= w_cnt_nxt;
         r_x_out <= w_x_out_nxt;
         r_y_out <= w_y_out_nxt;
      end
   end

   assign bus.x_out = r_x_out;
   assign bus.y_out = r_y_out;
endmodule

// File: tb/tb_rot_cordic_iter.sv
// Directed bench for rot_cordic_iter: table of hand-computed rotations plus
// backpressure, out_ready-early and mid-rotation reset sequences.
module tb_rot_cordic_iter;
   localparam int WIDTH = 16;
   localparam int ITER  = 14;
   localparam int TMO   = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   rot_cordic_iter_if #(.WIDTH(WIDTH)) bus_if ();

   rot_cordic_iter #(.WIDTH(WIDTH), .ITER(ITER)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      int ph;
      int ex;
      int ey;
      int tx;
      int ty;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input int act, input int exp, input int tol);
      n_checks++;
      if (act - exp > tol || exp - act > tol) begin
         n_errors++;
         $display("FAIL %s: got %0d, want %0d (+/- %0d)", name, act, exp, tol);
      end
   endtask

   // Called at a negedge with the engine idle; returns at the negedge after acceptance.
   task automatic accept(input int x, input int y, input int ph);
      bus_if.x_in     = x[15:0];
      bus_if.y_in     = y[15:0];
      bus_if.phase_in = ph[15:0];
      bus_if.in_valid = 1'b1;
      @(negedge clk);
      bus_if.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!bus_if.out_valid && cyc < TMO) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic release_out();
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      chk("release out_valid", int'(bus_if.out_valid), 0, 0);
      chk("release in_ready", int'(bus_if.in_ready), 1, 0);
   endtask

   initial begin
      int cyc;
      int seen;

      vecs[0] = '{8192, 0, 0, 13491, 0, 4, 4};
      vecs[1] = '{8192, 0, 16384, 0, 13491, 4, 4};
      vecs[2] = '{8192, 0, -32768, -13491, 0, 4, 4};
      vecs[3] = '{16383, 16383, 8192, 0, 32767, 4, 0};
      vecs[4] = '{0, 0, 12345, 0, 0, 0, 0};
      vecs[5] = '{8192, 0, -16384, 0, -13491, 4, 4};
      vecs[6] = '{0, 8192, 16385, -13491, 0, 4, 4};
      vecs[7] = '{0, -8192, -16385, -13491, 0, 4, 4};
      vecs[8] = '{-16383, -16383, 8192, 0, -32768, 8, 0};

      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b0;
      bus_if.x_in      = '0;
      bus_if.y_in      = '0;
      bus_if.phase_in  = '0;

      #12;
      chk("reset in_ready", int'(bus_if.in_ready), 1, 0);
      chk("reset out_valid", int'(bus_if.out_valid), 0, 0);
      chk("reset x_out", int'(bus_if.x_out), 0, 0);
      chk("reset y_out", int'(bus_if.y_out), 0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         chk($sformatf("v%0d in_ready", i), int'(bus_if.in_ready), 1, 0);
         accept(vecs[i].x, vecs[i].y, vecs[i].ph);
         chk($sformatf("v%0d busy", i), int'(bus_if.in_ready), 0, 0);
         wait_valid(cyc);
         chk($sformatf("v%0d latency", i), cyc, ITER, 0);
         chk($sformatf("v%0d x_out", i), int'(bus_if.x_out), vecs[i].ex, vecs[i].tx);
         chk($sformatf("v%0d y_out", i), int'(bus_if.y_out), vecs[i].ey, vecs[i].ty);
         release_out();
      end

      // Backpressure: result held 10 cycles while a new sample waits on in_valid.
      accept(8192, 0, 16384);
      wait_valid(cyc);
      chk("bp latency", cyc, ITER, 0);
      bus_if.x_in     = 16'sd8192;
      bus_if.y_in     = 16'sd0;
      bus_if.phase_in = 16'sd0;
      bus_if.in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("bp%0d out_valid", k), int'(bus_if.out_valid), 1, 0);
         chk($sformatf("bp%0d in_ready", k), int'(bus_if.in_ready), 0, 0);
         chk($sformatf("bp%0d x_out", k), int'(bus_if.x_out), 0, 4);
         chk($sformatf("bp%0d y_out", k), int'(bus_if.y_out), 13491, 4);
      end
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      chk("bp idle in_ready", int'(bus_if.in_ready), 1, 0);
      chk("bp idle out_valid", int'(bus_if.out_valid), 0, 0);
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      chk("bp pending accepted", int'(bus_if.in_ready), 0, 0);
      wait_valid(cyc);
      chk("bp2 latency", cyc, ITER, 0);
      chk("bp2 x_out", int'(bus_if.x_out), 13491, 4);
      chk("bp2 y_out", int'(bus_if.y_out), 0, 4);
      release_out();

      // out_ready held high throughout: no effect until DONE, then a one-cycle result.
      bus_if.out_ready = 1'b1;
      accept(8192, 0, -32768);
      wait_valid(cyc);
      chk("early rdy latency", cyc, ITER, 0);
      chk("early rdy x_out", int'(bus_if.x_out), -13491, 4);
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      chk("early rdy pulse", int'(bus_if.out_valid), 0, 0);
      chk("early rdy idle", int'(bus_if.in_ready), 1, 0);

      // Reset during iteration 5 abandons the sample.
      accept(16383, 16383, 8192);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid rst out_valid", int'(bus_if.out_valid), 0, 0);
      chk("mid rst in_ready", int'(bus_if.in_ready), 1, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < ITER + 4; k++) begin
         @(negedge clk);
         if (bus_if.out_valid) seen++;
      end
      chk("mid rst no output", seen, 0, 0);
      accept(8192, 0, 0);
      wait_valid(cyc);
      chk("post rst latency", cyc, ITER, 0);
      chk("post rst x_out", int'(bus_if.x_out), 13491, 4);
      chk("post rst y_out", int'(bus_if.y_out), 0, 4);
      release_out();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
